// File: rtl/ov7670_frame_gen.sv
// OV7670 camera-side emulator: reads a frame buffer and drives pclk/vsync/href/data
// with QQVGA-style timing, two bytes per pixel (RGB444 or gray).
module ov7670_frame_gen #(
  parameter int c_img_cols      = 80,
  parameter int c_img_rows      = 60,
  parameter int c_nb_img_pxls   = 13,
  parameter int c_nb_buf        = 12,
  parameter int c_clks_per_pclk = 4,
  parameter int c_hblank_pclks  = 16,
  parameter int c_vsync_lines   = 3,
  parameter int c_vbp_lines     = 2,
  parameter int c_vfp_lines     = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     rgbmode,
  output logic [c_nb_img_pxls-1:0] rd_addr,
  input  logic [c_nb_buf-1:0]      rd_data,
  output logic                     pclk,
  output logic                     vsync,
  output logic                     href,
  output logic [7:0]               data,
  output logic                     frame_done
);

  localparam int L  = 2*c_img_cols + c_hblank_pclks;
  localparam int CW = 16;
  localparam int DW = $clog2(c_clks_per_pclk);
  localparam int XW = $clog2(c_img_cols + 1);
  localparam int YW = $clog2(c_img_rows + 1);

  localparam logic [CW-1:0] VS_LAST  = CW'(c_vsync_lines*L - 1);
  localparam logic [CW-1:0] VBP_LAST = CW'(c_vbp_lines*L - 1);
  localparam logic [CW-1:0] VFP_LAST = CW'(c_vfp_lines*L - 1);
  localparam logic [CW-1:0] HB_LAST  = CW'(c_hblank_pclks - 1);
  localparam logic [CW-1:0] HB_PRE   = CW'(c_hblank_pclks - 2);
  localparam logic [XW-1:0] COL_LAST = XW'(c_img_cols - 1);
  localparam logic [YW-1:0] ROW_LAST = YW'(c_img_rows - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(c_clks_per_pclk - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(c_clks_per_pclk / 2);

  typedef enum logic [2:0] {IDLE, VSYNC, VBP, ACTIVE, HBLANK, VFP} state_t;

  state_t            state;
  logic [DW-1:0]     div_cnt;
  logic              fall;
  logic [CW-1:0]     cnt;
  logic [XW-1:0]     col;
  logic [YW-1:0]     row;
  logic              phase;
  logic              mode;
  logic [7:0]        sec;
  logic [c_nb_buf-1:0] pix;

  function automatic logic [7:0] byte_first(input logic m, input logic [c_nb_buf-1:0] w);
    return m ? {4'b0000, w[11:8]} : w[7:0];
  endfunction

  function automatic logic [7:0] byte_second(input logic m, input logic [c_nb_buf-1:0] w);
    return m ? w[7:0] : 8'h80;
  endfunction

  assign fall = (div_cnt == DIV_LAST);

  // Free-running divider; pix continuously tracks the 1-clk-latency read port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      pclk    <= 1'b0;
      pix     <= '0;
    end else begin
      div_cnt <= fall ? '0 : div_cnt + 1'b1;
      pclk    <= fall ? 1'b0 : ((div_cnt + 1'b1) >= DIV_HALF);
      pix     <= rd_data;
    end
  end

  // Frame FSM; every output moves only on a pclk fall. Requires c_hblank_pclks >= 2
  // so the next row's first read lands in the last blanking period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      vsync      <= 1'b0;
      href       <= 1'b0;
      data       <= 8'h00;
      rd_addr    <= '0;
      frame_done <= 1'b0;
      cnt        <= '0;
      col        <= '0;
      row        <= '0;
      phase      <= 1'b0;
      sec        <= 8'h00;
      mode       <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (fall) begin
        case (state)
          IDLE: if (enable) begin
            state <= VSYNC; vsync <= 1'b1; rd_addr <= '0; mode <= rgbmode; cnt <= '0; row <= '0;
          end
          VSYNC: if (cnt == VS_LAST) begin
            state <= VBP; vsync <= 1'b0; cnt <= '0;
          end else cnt <= cnt + 1'b1;
          VBP: if (cnt == VBP_LAST) begin
            state <= ACTIVE; href <= 1'b1; col <= '0; phase <= 1'b1;
            data <= byte_first(mode, pix); sec <= byte_second(mode, pix);
          end else cnt <= cnt + 1'b1;
          ACTIVE: if (phase) begin
            data <= sec; phase <= 1'b0;
            if (col != COL_LAST) rd_addr <= rd_addr + 1'b1;
          end else if (col == COL_LAST) begin
            state <= HBLANK; href <= 1'b0; data <= 8'h00; cnt <= '0;
          end else begin
            col <= col + 1'b1; phase <= 1'b1;
            data <= byte_first(mode, pix); sec <= byte_second(mode, pix);
          end
          HBLANK: if (cnt == HB_LAST) begin
            if (row != ROW_LAST) begin
              state <= ACTIVE; href <= 1'b1; row <= row + 1'b1; col <= '0; phase <= 1'b1;
              data <= byte_first(mode, pix); sec <= byte_second(mode, pix);
            end else begin
              state <= VFP; cnt <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
            if (cnt == HB_PRE && row != ROW_LAST) rd_addr <= rd_addr + 1'b1;
          end
          VFP: if (cnt == VFP_LAST) begin
            frame_done <= 1'b1;
            if (enable) begin
              state <= VSYNC; vsync <= 1'b1; rd_addr <= '0; mode <= rgbmode; cnt <= '0; row <= '0;
            end else state <= IDLE;
          end else cnt <= cnt + 1'b1;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ov7670_frame_gen.sv
// Bench for ov7670_frame_gen in a small 4x2 configuration: scoreboard on bytes,
// monitor on sync timing and read-address progress.
module tb_ov7670_frame_gen;
  logic        clk = 1'b0, rst = 1'b1, enable = 1'b0, rgbmode = 1'b1;
  logic [12:0] rd_addr;
  logic [11:0] rd_data;
  logic        pclk, vsync, href, frame_done;
  logic [7:0]  data;
  logic [11:0] base = 12'h100;
  int          cyc = 0, errors = 0, checks = 0;
  bit          sb_on = 1'b1;
  logic [7:0]  exp_q[$];

  ov7670_frame_gen #(
    .c_img_cols(4), .c_img_rows(2), .c_nb_img_pxls(13), .c_nb_buf(12),
    .c_clks_per_pclk(4), .c_hblank_pclks(4), .c_vsync_lines(1),
    .c_vbp_lines(1), .c_vfp_lines(1)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .rgbmode(rgbmode),
    .rd_addr(rd_addr), .rd_data(rd_data), .pclk(pclk), .vsync(vsync),
    .href(href), .data(data), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Frame buffer model: word i = base + i, one clk of read latency.
  always @(posedge clk) begin
    rd_data <= base + rd_addr[11:0];
    cyc     <= cyc + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic sel(input int w);
    case (w)
      0:       return vsync;
      1:       return href;
      default: return frame_done;
    endcase
  endfunction

  task automatic wait_for(input int which, input logic val, input int budget, output int n);
    n = 0;
    while (sel(which) !== val) begin
      @(negedge clk);
      n++;
      if (n > budget) begin
        checks++; errors++;
        $display("FAIL timeout_%0d: waited %0d clks", which, n);
        return;
      end
    end
  endtask

  // Monitor: timing, address progress and scoreboard pops, sampled 1 time unit after clk rise.
  logic        pp = 0, pv = 0, ph = 0, prst = 1;
  logic [7:0]  pd = 0;
  logic [12:0] pa = 0;
  int          vr_t = 0, vf_t = 0, hr_t = 0, href_cnt = 0;
  bit          first_href = 0;

  always @(posedge clk) begin
    #1;
    if (!rst && !prst) begin
      if (vsync !== pv || href !== ph || data !== pd) chk("edge_align", {30'd0, pp, pclk}, 32'd2);
      if (rd_addr !== pa) chk("rd_addr_step", rd_addr, (vsync && !pv) ? 32'd0 : 32'(pa) + 1);
      if (frame_done) begin
        chk("frame_period", cyc - vr_t, 240);
        chk("href_pulses", href_cnt, 2);
        chk("addr_last", pa, 7);
      end
      if (vsync && !pv) begin vr_t = cyc; href_cnt = 0; chk("addr_at_vsync", rd_addr, 0); end
      if (!vsync && pv) begin chk("vsync_width", cyc - vr_t, 48); vf_t = cyc; first_href = 1; end
      if (href && !ph) begin
        href_cnt++; hr_t = cyc;
        if (first_href) chk("vbp_gap", cyc - vf_t, 48);
        first_href = 0;
      end
      if (!href && ph) chk("href_width", cyc - hr_t, 32);
      if (pclk && !pp && href && sb_on) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL byte: got %0h want none (cyc %0d)", data, cyc);
        end else chk("byte", data, exp_q.pop_front());
      end
    end
    pp = pclk; pv = vsync; ph = href; pd = data; pa = rd_addr; prst = rst;
  end

  // One frame: queue its expected bytes, flip rgbmode mid-frame, optionally drop enable in row 1.
  task automatic run_frame(input logic m, input logic m_next, input logic [11:0] b, input bit drop);
    int n;
    logic [11:0] w;
    wait_for(0, 1'b1, 300, n);
    base = b;
    for (int i = 0; i < 8; i++) begin
      w = b + 12'(i);
      if (m) begin exp_q.push_back({4'h0, w[11:8]}); exp_q.push_back(w[7:0]); end
      else   begin exp_q.push_back(w[7:0]);          exp_q.push_back(8'h80);  end
    end
    wait_for(1, 1'b1, 200, n);
    rgbmode = m_next;
    if (drop) begin
      wait_for(1, 1'b0, 100, n);
      wait_for(1, 1'b1, 100, n);
      repeat (8) @(negedge clk);
      enable = 1'b0;
    end
    wait_for(2, 1'b1, 400, n);
    chk("sb_empty", exp_q.size(), 0);
    @(negedge clk);
    chk("done_pulse", frame_done, 0);
    chk("vsync_after_done", vsync, enable);
  endtask

  initial begin
    int n, rises, hi;
    logic lastp;
    repeat (2) @(negedge clk);
    chk("rst_pclk", pclk, 0);   chk("rst_vsync", vsync, 0); chk("rst_href", href, 0);
    chk("rst_data", data, 0);   chk("rst_addr", rd_addr, 0); chk("rst_done", frame_done, 0);
    rst = 1'b0; enable = 1'b1; rgbmode = 1'b1;

    run_frame(1'b1, 1'b0, 12'h100, 1'b0);   // 01,00,01,01,01,02,...
    run_frame(1'b0, 1'b1, 12'h0A0, 1'b0);   // A0,80,A1,80,... despite mid-frame toggle
    run_frame(1'b1, 1'b1, 12'h0C3, 1'b1);   // enable dropped in row 1

    rises = 0; hi = 0; lastp = pclk;
    repeat (100) begin
      @(negedge clk);
      if (pclk && !lastp) rises++;
      lastp = pclk;
      if (vsync || href) hi++;
    end
    chk("idle_pclk_rises", rises, 25);
    chk("idle_quiet", hi, 0);

    enable = 1'b1;
    wait_for(0, 1'b1, 8, n);
    chk("idle_start", (n <= 4) ? 1 : 0, 1);
    sb_on = 1'b0;
    wait_for(1, 1'b1, 200, n);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_pclk", pclk, 0);  chk("arst_vsync", vsync, 0); chk("arst_href", href, 0);
    chk("arst_data", data, 0);  chk("arst_addr", rd_addr, 0); chk("arst_done", frame_done, 0);
    repeat (2) @(negedge clk);
    exp_q.delete();
    rst = 1'b0; sb_on = 1'b1;
    wait_for(0, 1'b1, 8, n);
    chk("rst_restart", (n <= 4) ? 1 : 0, 1);
    chk("rst_restart_addr", rd_addr, 0);
    run_frame(1'b1, 1'b1, 12'h055, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
